// File: rtl/invsqrt_pkg.sv
// Shared definitions for the InvSqrt datapath: default widths, shift
// direction encodings and the shifter scheduler state encoding.
package invsqrt_pkg;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_SHIFT_W = 8;
  localparam int DEF_OUT_W   = 32;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/shifter_sched_if.sv
// Bundle of the requester handshake and the shifter launch/return signals
// seen by the shifter scheduler.
//
// Handshake semantics: a requester raises req_valid[i] with a stable
// payload (req_dir/req_data/req_shift slice i) and keeps both unchanged
// until it observes the one-cycle req_ready[i] pulse; that pulse marks the
// transfer. The owner later sees exactly one resp_valid[i] pulse, with
// resp_data/resp_err valid in that same cycle. Towards the shifter,
// sh_load is a one-cycle start pulse with sh_dir/sh_in/sh_shift stable until
// the result is taken; sh_ready is a level flag qualifying sh_shifted.
interface shifter_sched_if
  import invsqrt_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int OUT_W   = DEF_OUT_W
);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_dir;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ*SHIFT_W-1:0] req_shift;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         resp_valid;
  logic [OUT_W-1:0]         resp_data;
  logic                     resp_err;
  logic                     sh_load;
  logic                     sh_dir;
  logic [DATA_W-1:0]        sh_in;
  logic [SHIFT_W-1:0]       sh_shift;
  logic [OUT_W-1:0]         sh_shifted;
  logic                     sh_ready;

  // Scheduler side.
  modport slave (
    input  req_valid, req_dir, req_data, req_shift, sh_shifted, sh_ready,
    output req_ready, resp_valid, resp_data, resp_err,
           sh_load, sh_dir, sh_in, sh_shift
  );

  // Requesters plus shifter side.
  modport master (
    output req_valid, req_dir, req_data, req_shift, sh_shifted, sh_ready,
    input  req_ready, resp_valid, resp_data, resp_err,
           sh_load, sh_dir, sh_in, sh_shift
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after the
// pointer (wrapping), and moves the pointer past the winner when the grant
// is taken.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W:0]   sum;
  logic [IDX_W:0]   nxt;

  // Search from the pointer for the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (sum >= N_LIM) sum = sum - N_LIM;
      if (!any_gnt && req[sum[IDX_W-1:0]]) begin
        any_gnt = 1'b1;
        gnt_idx = sum[IDX_W-1:0];
      end
    end
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

  // Pointer value one past the current winner, wrapping at N_REQ.
  always_comb begin
    nxt = {1'b0, gnt_idx} + (IDX_W+1)'(1);
    if (nxt >= N_LIM) nxt = '0;
    ptr_next = nxt[IDX_W-1:0];
  end

  // Pointer advances only when the grant is actually consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_en && any_gnt) begin
      ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/shifter_sched.sv
// Time-shares one multi-cycle barrel shifter between N_REQ requesters:
// round-robin grant, one load pulse per operation, timeout on a silent
// shifter, and a bypass with a zero result for shift amounts >= OUT_W.
module shifter_sched
  import invsqrt_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  shifter_sched_if.slave    bus,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SHIFT_W:0]  SHIFT_LIM = (SHIFT_W+1)'(OUT_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_gnt;
  logic               gnt_en;

  logic               sel_dir;
  logic [DATA_W-1:0]  sel_data;
  logic [SHIFT_W-1:0] sel_shift;
  logic               bypass;
  logic               timeout_hit;

  logic [IDX_W-1:0]   owner_q;
  logic [OUT_W-1:0]   result_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  assign gnt_en      = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;
  assign bypass      = ({1'b0, sel_shift} >= SHIFT_LIM);
  assign timeout_hit = (cnt_q == CNT_LAST);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Select the granted requester's payload from the packed buses.
  always_comb begin
    sel_dir   = 1'b0;
    sel_data  = '0;
    sel_shift = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_dir   = bus.req_dir[i];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
        sel_shift = bus.req_shift[i*SHIFT_W +: SHIFT_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; sh_ready is only looked at in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = bypass ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.sh_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath: latch on grant, launch, capture, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready  <= '0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
      bus.sh_load    <= 1'b0;
      bus.sh_dir     <= 1'b0;
      bus.sh_in      <= '0;
      bus.sh_shift   <= '0;
      owner_q        <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      bus.req_ready  <= '0;
      bus.resp_valid <= '0;
      bus.sh_load    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_gnt) begin
            owner_q       <= gnt_idx;
            bus.req_ready <= gnt;
            if (bypass) begin
              result_q <= '0;
              err_q    <= 1'b0;
            end else begin
              bus.sh_load  <= 1'b1;
              bus.sh_dir   <= sel_dir;
              bus.sh_in    <= sel_data;
              bus.sh_shift <= sel_shift;
            end
          end
        end
        ISSUE: begin
          cnt_q <= '0;
        end
        WAIT: begin
          if (bus.sh_ready) begin
            result_q <= bus.sh_shifted;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          bus.resp_valid[owner_q] <= 1'b1;
          bus.resp_data           <= result_q;
          bus.resp_err            <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_sched.sv
// Directed bench for shifter_sched with a small shifter model that raises
// sh_ready three cycles after sh_load (or never, when hung).
module tb_shifter_sched;
  import invsqrt_pkg::*;

  localparam int N_REQ   = 2;
  localparam int DATA_W  = 24;
  localparam int SHIFT_W = 8;
  localparam int OUT_W   = 32;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_t dbg_state;

  shifter_sched_if #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)
  ) bus ();

  shifter_sched #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W),
    .TIMEOUT(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shifter model ----------------
  logic       sh_hang;
  logic [1:0] sh_delay;

  // Model: latch operands on sh_load, ready 3 cycles after load unless hung.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sh_ready   <= 1'b0;
      bus.sh_shifted <= '0;
      sh_delay       <= '0;
    end else if (bus.sh_load) begin
      bus.sh_ready   <= 1'b0;
      bus.sh_shifted <= (bus.sh_dir == DIR_LEFT) ? (32'(bus.sh_in) << bus.sh_shift)
                                                 : (32'(bus.sh_in) >> bus.sh_shift);
      sh_delay       <= sh_hang ? 2'd0 : 2'd2;
    end else if (sh_delay != 2'd0) begin
      sh_delay     <= sh_delay - 2'd1;
      bus.sh_ready <= (sh_delay == 2'd1);
    end
  end

  // ---------------- monitors ----------------
  int load_count;
  int resp_count;
  int overlap_count;

  // Count load pulses, response pulses and any load seen during WAIT.
  always @(negedge clk) begin
    if (bus.sh_load) load_count++;
    if (bus.resp_valid != '0) resp_count++;
    if (bus.sh_load && dbg_state == WAIT) overlap_count++;
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic dir, input logic [23:0] data,
                         input logic [7:0] shift);
    bus.req_valid[idx]                 = 1'b1;
    bus.req_dir[idx]                   = dir;
    bus.req_data[idx*DATA_W +: DATA_W] = data;
    bus.req_shift[idx*SHIFT_W +: SHIFT_W] = shift;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready == '0 && n < 200);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.resp_valid == '0 && n < 200);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),  32'h0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
    check({tag, "_resp_data"},  bus.resp_data,       32'h0);
    check({tag, "_resp_err"},   32'(bus.resp_err),   32'h0);
    check({tag, "_sh_load"},    32'(bus.sh_load),    32'h0);
    check({tag, "_sh_dir"},     32'(bus.sh_dir),     32'h0);
    check({tag, "_sh_in"},      32'(bus.sh_in),      32'h0);
    check({tag, "_sh_shift"},   32'(bus.sh_shift),   32'h0);
    check({tag, "_busy"},       32'(busy),           32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int n;
  int loads_before;
  int resp_before;
  logic [1:0]  exp_gnt;
  logic [31:0] exp_data;

  initial begin
    checks = 0; errors = 0;
    load_count = 0; resp_count = 0; overlap_count = 0;
    sh_hang       = 1'b0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_dir   = '0;
    bus.req_data  = '0;
    bus.req_shift = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Step 1: req0 left shift by 6
    set_req(0, 1'b1, 24'h010101, 8'd6);
    @(negedge clk);
    check("s1_req_ready", 32'(bus.req_ready), 32'h1);
    check("s1_sh_load",   32'(bus.sh_load),   32'h1);
    check("s1_sh_in",     32'(bus.sh_in),     32'h010101);
    check("s1_sh_shift",  32'(bus.sh_shift),  32'd6);
    check("s1_sh_dir",    32'(bus.sh_dir),    32'h1);
    check("s1_busy",      32'(busy),          32'h1);
    bus.req_valid = '0;
    wait_resp(n);
    check("s1_latency",   n,                   5);
    check("s1_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("s1_resp_data", bus.resp_data,        32'h00404040);
    check("s1_resp_err",  32'(bus.resp_err),    32'h0);
    check("s1_loads",     load_count,           1);
    @(negedge clk);
    check("s1_resp_pulse", 32'(bus.resp_valid), 32'h0);
    check("s1_data_hold", bus.resp_data,        32'h00404040);
    check("s1_idle",      32'(busy),            32'h0);

    // Step 2: req1 right shift by 4
    set_req(1, 1'b0, 24'h010101, 8'd4);
    @(negedge clk);
    check("s2_req_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    wait_resp(n);
    check("s2_latency",    n,                   5);
    check("s2_resp_valid", 32'(bus.resp_valid), 32'h2);
    check("s2_resp_data",  bus.resp_data,       32'h00001010);

    // Step 3: both held valid, expect 0,1,0,1
    @(negedge clk);
    loads_before = load_count;
    set_req(0, 1'b1, 24'h000003, 8'd2);
    set_req(1, 1'b0, 24'h800000, 8'd20);
    for (int k = 0; k < 4; k++) begin
      exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (k % 2 == 0) ? 32'h0000000C : 32'h00000008;
      wait_ready(n);
      check("s3_req_ready", 32'(bus.req_ready), 32'(exp_gnt));
      wait_resp(n);
      check("s3_resp_valid", 32'(bus.resp_valid), 32'(exp_gnt));
      check("s3_resp_data",  bus.resp_data,       exp_data);
    end
    bus.req_valid = '0;
    check("s3_loads",   load_count - loads_before, 4);
    check("s3_overlap", overlap_count,             0);
    @(negedge clk);

    // Step 4: out-of-range shift bypasses the shifter
    loads_before = load_count;
    set_req(0, 1'b1, 24'h123456, 8'd40);
    @(negedge clk);
    check("s4_req_ready", 32'(bus.req_ready), 32'h1);
    check("s4_sh_load",   32'(bus.sh_load),   32'h0);
    check("s4_state",     32'(dbg_state),     32'(RESP));
    bus.req_valid = '0;
    wait_resp(n);
    check("s4_latency",    n,                   1);
    check("s4_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("s4_resp_data",  bus.resp_data,       32'h0);
    check("s4_resp_err",   32'(bus.resp_err),   32'h0);
    check("s4_loads",      load_count - loads_before, 0);

    // Step 5: hung shifter times out, then a normal request
    sh_hang = 1'b1;
    set_req(0, 1'b1, 24'h000001, 8'd1);
    @(negedge clk);
    check("s5_req_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    wait_resp(n);
    check("s5_latency",    n,                   66);
    check("s5_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("s5_resp_err",   32'(bus.resp_err),   32'h1);
    check("s5_resp_data",  bus.resp_data,       32'h0);
    sh_hang = 1'b0;
    set_req(1, 1'b1, 24'h000001, 8'd31);
    @(negedge clk);
    check("s5b_req_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    wait_resp(n);
    check("s5b_latency",    n,                   5);
    check("s5b_resp_valid", 32'(bus.resp_valid), 32'h2);
    check("s5b_resp_err",   32'(bus.resp_err),   32'h0);
    check("s5b_resp_data",  bus.resp_data,       32'h80000000);

    // Step 6: reset in WAIT drops the request and the pointer
    set_req(0, 1'b1, 24'h0000FF, 8'd3);
    @(negedge clk);
    check("s6_req_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    @(negedge clk);
    check("s6_in_wait", 32'(dbg_state), 32'(WAIT));
    resp_before = resp_count;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("s6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("s6_no_resp", resp_count - resp_before, 0);
    set_req(0, 1'b1, 24'h000005, 8'd1);
    set_req(1, 1'b0, 24'h000040, 8'd2);
    @(negedge clk);
    check("s6_first_gnt", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    wait_resp(n);
    check("s6_latency",    n,                   5);
    check("s6_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("s6_resp_data",  bus.resp_data,       32'h0000000A);
    repeat (3) @(negedge clk);
    check("s6_end_idle",  32'(busy),          32'h0);
    check("s6_end_ready", 32'(bus.req_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_sched.md
Name: shifter_sched

Overview:
- Time-shares the single multi-cycle barrel shifter of the InvSqrt datapath between N_REQ requesters, e.g. mantissa normalise and exponent-align stages.
- Arbitrates round-robin and holds the shifter operands stable for the whole operation.
- Launches the shifter with a load pulse, waits for its ready flag (with a timeout) and returns the 32-bit result to the owning requester.
- Bypasses the shifter for out-of-range shift amounts.

Parameters:
- N_REQ, 2, number of requesters
- DATA_W, 24, shifter input width
- SHIFT_W, 8, shift-amount width
- OUT_W, 32, shifter result width
- TIMEOUT, 64, maximum WAIT cycles before an error response

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_dir  in  N_REQ  per-requester direction, 1 = left, 0 = right
- req_data  in  N_REQ*DATA_W  packed operands, requester i at bits [i*DATA_W +: DATA_W]
- req_shift  in  N_REQ*SHIFT_W  packed shift amounts
- req_ready  out  N_REQ  one-cycle accept pulse
- resp_valid  out  N_REQ  one-cycle result pulse to the owner
- resp_data  out  OUT_W  shared result bus
- resp_err  out  1  result invalid (timeout); qualified by resp_valid
- sh_load  out  1  one-cycle start pulse to the shifter
- sh_dir  out  1  shifter direction
- sh_in  out  DATA_W  shifter operand
- sh_shift  out  SHIFT_W  shifter amount
- sh_shifted  in  OUT_W  shifter result
- sh_ready  in  1  shifter result valid (level)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, RR pointer=0.
- All outputs reset to 0: req_ready, resp_valid, resp_data, resp_err, sh_load, sh_dir, sh_in, sh_shift, busy.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE, plus IDLE -> RESP on bypass.
- IDLE: if any req_valid is set, grant the first set bit at or after the pointer (wrapping at N_REQ).
  - Latch that requester's dir/data/shift and its owner index; pointer <= (grant+1) mod N_REQ.
  - req_ready[grant] pulses high in the following cycle. A requester holds valid and payload until it sees req_ready, then may drop them.
  - If latched shift >= OUT_W: go to RESP with resp_data=0, resp_err=0; sh_load is never asserted.
  - Otherwise go to ISSUE.
- ISSUE: sh_load=1 for exactly one cycle; sh_dir/sh_in/sh_shift hold the latched values from ISSUE through the end of WAIT. Next state is WAIT and the timeout counter clears.
- WAIT: sh_ready is sampled from the first WAIT cycle (never in ISSUE, where it may be stale).
  - sh_ready=1: capture sh_shifted into resp_data, resp_err=0, go to RESP.
  - Counter reaches TIMEOUT without sh_ready: resp_data=0, resp_err=1, go to RESP.
- RESP: resp_valid[owner]=1 for one cycle; resp_data/resp_err hold until the next RESP. Next state is IDLE.
- Latency from accepting edge to resp_valid = 1 (ISSUE) + k (WAIT cycles up to and including sh_ready) + 1. Bypass latency = 1.
- Throughput: the next grant is evaluated in the IDLE cycle after RESP.
- Requests arriving while busy are ignored; req_valid stays high until that requester is granted.
- req_valid dropped before its grant: no effect.
- Simultaneous requests: pointer order only.
- Reset mid-operation clears everything immediately. The in-flight request is lost with no response, and the shifter is expected to be reset by the same rst_n.
- Shift amount of 0 goes through the shifter normally, not the bypass.

Decomposition:
- Shared package (invsqrt_pkg): DATA_W/SHIFT_W/OUT_W defaults, direction constants DIR_LEFT=1 / DIR_RIGHT=0, FSM state encodings IDLE/ISSUE/WAIT/RESP.
- Sub-module rr_arbiter (N_REQ): request vector, pointer, grant-enable in; one-hot grant, grant index, any-grant out; owns the pointer register.

Test Plan (shifter model asserts sh_ready 3 cycles after sh_load):
- After reset: all outputs 0, busy=0. Then req0: dir=1, data=0x010101, shift=6 -> one sh_load, then resp_valid[0] with resp_data=0x00404040, resp_err=0, 5 cycles after the accepting edge.
- req1: dir=0, data=0x010101, shift=4 -> resp_valid[1], resp_data=0x00001010; resp_valid[0] stays 0.
- Both requesters held valid after reset -> grant order 0,1,0,1; req_ready pulses alternate; no sh_load overlaps WAIT.
- req0 with shift=40 -> no sh_load; resp_valid[0] one cycle after accept; resp_data=0, resp_err=0.
- Shifter model never raises sh_ready -> after 64 WAIT cycles: resp_valid[0]=1, resp_err=1, resp_data=0; then the next request completes normally.
- rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously, no resp_valid for the lost request; pointer back to 0, so the following simultaneous requests grant requester 0 first.
